adder_sequencer: RTL and testbench

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

---
 rtl/adder_seq_pkg.sv | 19 +
 rtl/adder_sequencer_parallel_adder.sv | 24 ++
 rtl/adder_sequencer.sv | 135 +++++++++++++
 tb/tb_adder_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_pkg
// Purpose  : Shared byte width and FSM state encodings for adder_sequencer.
// Revision : 1.0
// ============================================================================
package adder_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/adder_sequencer_parallel_adder.sv
`default_nettype none
// ============================================================================
// Module   : Parallel_Adder
// Purpose  : 8-bit adder with carry-in and carry-out; one byte lane per cycle.
// Revision : 1.0
// ============================================================================
module Parallel_Adder
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign sum    = w_full[BYTE_W-1:0];
  assign cout   = w_full[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adder_sequencer
// Purpose  : Multi-cycle byte-serial adder; one byte per clock, registered
//            carry between bytes. Define ADDER_SEQ_SUB_EN to add port sub.
// Revision : 1.0
// ============================================================================
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int NUM_BYTES = 4
)
(
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                        sub,
`endif
  input  logic                        start,
  input  logic [BYTE_W*NUM_BYTES-1:0] a,
  input  logic [BYTE_W*NUM_BYTES-1:0] b,
  input  logic                        cin,
  output logic                        ready,
  output logic                        done,
  output logic [BYTE_W*NUM_BYTES-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic [IDX_W-1:0]  r_idx;

  logic              w_sub;
  logic              w_accept;
  logic              w_last;
  logic [W-1:0]      w_b_eff;
  logic              w_cin_eff;
  logic [BYTE_W-1:0] w_byte_sum;
  logic              w_byte_cout;

`ifdef ADDER_SEQ_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is folded into the operands at accept time: B' = ~B, carry-in = 1.
  assign w_b_eff   = w_sub ? ~b : b;
  assign w_cin_eff = w_sub ? 1'b1 : cin;
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_last    = (r_idx == LAST_IDX);

  Parallel_Adder u_byte_adder (
    .a    (r_a[r_idx*BYTE_W +: BYTE_W]),
    .b    (r_b[r_idx*BYTE_W +: BYTE_W]),
    .cin  (r_carry),
    .sum  (w_byte_sum),
    .cout (w_byte_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (r_state)
      ST_IDLE: ready = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_eff;
      r_carry <= w_cin_eff;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum[r_idx*BYTE_W +: BYTE_W] <= w_byte_sum;
      r_carry <= w_byte_cout;
      if (w_last) begin
        r_cout <= w_byte_cout;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_byte_sum[BYTE_W-1] != r_a[W-1]);
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_sequencer
// Purpose  : Scoreboard bench for adder_sequencer (NUM_BYTES=4); covers the
//            sub port when ADDER_SEQ_SUB_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_adder_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_in;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;
  int done_count = 0;
  logic [W+1:0] exp_q[$];

  adder_sequencer #(.NUM_BYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ADDER_SEQ_SUB_EN
    .sub   (sub_in),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: unsigned result for sum/cout, signed range test for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tc, input logic ts);
    logic [W:0] u;
    longint     sa, sb, ci, s;
    logic       o;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    ci = tc ? 64'sd1 : 64'sd0;
    if (ts) begin
      u = {1'b0, ta} - {1'b0, tb};
      u[W] = (ta >= tb);
      s = sa - sb;
    end else begin
      u = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      s = sa + sb + ci;
    end
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {u[W-1:0], u[W], o};
  endfunction

  // Monitor: pops one expectation per done pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      check("done_pulse_width", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got sum=%h with no pending request", sum);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result", {30'd0, sum, cout, ovf}, {30'd0, e});
      end
    end
    prev_done <= done;
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts, input bit inject);
    logic [W+1:0] e;
    logic [63:0]  m;
    int           got;
    int           wait_n;
    wait_n = 0;
    while (!ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (!ready) check("ready_timeout", 64'd0, 64'd1);
    e = model(ta, tb, tc, ts);
    exp_q.push_back(e);
    a = ta; b = tb; cin = tc; sub_in = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = -1;
    for (int k = 1; k <= NB + 3; k++) begin
      @(posedge clk); #1;
      if (k < NB) begin
        m = (64'd1 << (8 * k)) - 64'd1;
        check("partial_sum", {32'd0, sum}, {32'd0, e[W+1:2]} & m);
        if (k == 1) check("ready_busy", {63'd0, ready}, 64'd0);
      end
      if (inject && k == 1) begin
        start = 1'b1; a = 32'd5; b = 32'd5; cin = 1'b0;
      end
      if (inject && k == 2) start = 1'b0;
      if (done) begin
        got = k;
        break;
      end
    end
    check("latency", 64'(got), 64'(NB));
  endtask

  initial begin
    int saved;
    logic [W-1:0] ra, rb;
    logic         rs;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_in = 1'b0;
    #12;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_sum",   {32'd0, sum},   64'd0);
    check("rst_flags", {62'd0, cout, ovf}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h0000000F, 32'h00000001, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
    do_op(32'h11223344, 32'h11111111, 1'b0, 1'b0, 1'b0);
    do_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1);
`ifdef ADDER_SEQ_SUB_EN
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0);
`endif

    // Abort mid-RUN while byte 2 is being computed.
    while (!ready) begin @(posedge clk); #1; end
    exp_q.push_back(model(32'h01020304, 32'h01010101, 1'b0, 1'b0));
    a = 32'h01020304; b = 32'h01010101; cin = 1'b0; sub_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    saved = done_count;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_sum",   {32'd0, sum},   64'd0);
    check("abort_flags", {62'd0, cout, ovf}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_count), 64'(saved));

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: begin ra = ra | 32'h7FFFFF00; rb = 32'h000000FF; end
        default: ;
      endcase
`ifdef ADDER_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, 1'($urandom_range(0, 1)), rs, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
